// File: rtl/blk_seq.sv
// Batch sequencer for the cipher core: optional key load, then cmd_cnt chained or fixed-input runs.
// Optional build macro SEQ_TIMEOUT_EN adds a kvld/dvld watchdog that sets the sticky seq_err flag.
module blk_seq #(
    parameter int DIN_W  = 496,
    parameter int DOUT_W = 128,
    parameter int GAP    = 16,
    parameter int TMO    = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    input  logic              cmd_key,
    input  logic              cmd_chain,
    input  logic [15:0]       cmd_cnt,
    input  logic [DIN_W-1:0]  cmd_din,
    output logic [DIN_W-1:0]  blk_din,
    output logic              blk_krdy,
    output logic              blk_drdy,
    input  logic              blk_kvld,
    input  logic              blk_dvld,
    input  logic [DOUT_W-1:0] blk_dout,
    output logic              blk_rstn,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic [15:0]       seq_left,
    output logic [DOUT_W-1:0] seq_dout,
    output logic              trig
);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KLOAD, S_KWAIT, S_DLOAD, S_DWAIT, S_GAPW, S_FIN
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [DIN_W-1:0]   din_r;
    logic [DOUT_W-1:0]  dout_r;
    logic [15:0]        left_r;
    logic [GW-1:0]      gap_cnt_r;
    logic               chain_r, krdy_r, drdy_r, busy_r, done_r, trig_r, brstn_r;
    logic               abort_s, accept_s, cap_s, tmo_s;

    // Next-state decode; abort overrides everything, including a same-cycle completion pulse
    always_comb begin
        state_nxt_s = state_r;
        abort_s     = cmd_abort && (state_r != S_IDLE);
        accept_s    = 1'b0;
        cap_s       = 1'b0;
        if (abort_s) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cmd_start) begin
                        accept_s = 1'b1;
                        if (cmd_key)                  state_nxt_s = S_KLOAD;
                        else if (cmd_cnt != 16'd0)    state_nxt_s = S_DLOAD;
                        else                          state_nxt_s = S_FIN;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_KLOAD: state_nxt_s = S_KWAIT;
                S_KWAIT: begin
                    if (blk_kvld)   state_nxt_s = (left_r != 16'd0) ? S_DLOAD : S_FIN;
                    else if (tmo_s) state_nxt_s = S_IDLE;
                    else            state_nxt_s = S_KWAIT;
                end
                S_DLOAD: state_nxt_s = S_DWAIT;
                S_DWAIT: begin
                    if (blk_dvld) begin
                        cap_s       = 1'b1;
                        state_nxt_s = (left_r <= 16'd1) ? S_FIN : S_GAPW;
                    end else if (tmo_s) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_DWAIT;
                    end
                end
                S_GAPW: begin
                    if (gap_cnt_r == GW'(GAP - 1)) state_nxt_s = S_DLOAD;
                    else                           state_nxt_s = S_GAPW;
                end
                S_FIN:   state_nxt_s = S_IDLE;
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // State, registered strobes and the data/result path
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= S_IDLE;
            din_r     <= {DIN_W{1'b0}};
            dout_r    <= {DOUT_W{1'b0}};
            left_r    <= 16'd0;
            gap_cnt_r <= {GW{1'b0}};
            chain_r   <= 1'b0;
            krdy_r    <= 1'b0;
            drdy_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            trig_r    <= 1'b0;
            brstn_r   <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s != S_IDLE);
            krdy_r    <= (state_nxt_s == S_KLOAD);
            drdy_r    <= (state_nxt_s == S_DLOAD);
            done_r    <= (state_nxt_s == S_FIN);
            trig_r    <= (state_nxt_s == S_DLOAD) || (state_nxt_s == S_DWAIT);
            brstn_r   <= !(abort_s || tmo_s);
            gap_cnt_r <= (state_r == S_GAPW && state_nxt_s == S_GAPW) ? gap_cnt_r + GW'(1) : {GW{1'b0}};
            if (accept_s) begin
                chain_r <= cmd_chain;
                left_r  <= cmd_cnt;
                din_r   <= cmd_din;
            end else if (cap_s) begin
                left_r <= left_r - 16'd1;
                dout_r <= blk_dout;
                if (chain_r) din_r[DOUT_W-1:0] <= blk_dout;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tmo_cnt_r;
    logic          err_r;

    assign tmo_s = ((state_r == S_KWAIT) || (state_r == S_DWAIT)) && (tmo_cnt_r == TW'(TMO - 1));

    // Wait-cycle counter, restarted on every state entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (state_nxt_s != state_r) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if ((state_r == S_KWAIT) || (state_r == S_DWAIT)) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= {TW{1'b0}};
        end
    end

    // Sticky timeout flag, cleared only by an accepted start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                  err_r <= 1'b0;
        else if (accept_s)          err_r <= 1'b0;
        else if (tmo_s && !abort_s) err_r <= 1'b1;
        else                        err_r <= err_r;
    end

    assign seq_err = err_r;
`else
    assign tmo_s   = 1'b0;
    assign seq_err = 1'b0;
`endif

    assign blk_din  = din_r;
    assign blk_krdy = krdy_r;
    assign blk_drdy = drdy_r;
    assign blk_rstn = brstn_r;
    assign seq_busy = busy_r;
    assign seq_done = done_r;
    assign seq_left = left_r;
    assign seq_dout = dout_r;
    assign trig     = trig_r;
endmodule

// File: tb/tb_blk_seq.sv
// Bench for blk_seq: core model (dout = din[127:0] + 1), sequence vector table, hand-written corner cases.
module tb_blk_seq;
    localparam int DIN_W = 496, DOUT_W = 128, GAP = 16, TMO = 1024, HI_W = DIN_W - DOUT_W;

    logic              clk = 1'b0, rstn = 1'b0;
    logic              cmd_start = 1'b0, cmd_abort = 1'b0, cmd_key = 1'b0, cmd_chain = 1'b0;
    logic [15:0]       cmd_cnt = 16'd0;
    logic [DIN_W-1:0]  cmd_din = {DIN_W{1'b0}};
    logic [DIN_W-1:0]  blk_din;
    logic              blk_krdy, blk_drdy, blk_rstn, seq_busy, seq_done, seq_err, trig;
    logic              blk_kvld = 1'b0, blk_dvld = 1'b0;
    logic [DOUT_W-1:0] blk_dout = {DOUT_W{1'b0}};
    logic [15:0]       seq_left;
    logic [DOUT_W-1:0] seq_dout;

    int checks = 0, failures = 0;
    int core_lat = 10;
    bit core_en = 1'b1;
    int dcnt = 0, kcnt = 0;
    logic [DOUT_W-1:0] din_snap = {DOUT_W{1'b0}};
    int n_krdy = 0, n_drdy = 0, n_done = 0, trig_len = 0;
    int trig_hist[$];
    logic [15:0] left_hist[$];
    logic [15:0] left_prev = 16'd0;
    logic [HI_W-1:0] up_pat = {23{16'hC3A5}};

    blk_seq #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .GAP(GAP), .TMO(TMO)) dut (
        .clk(clk), .rstn(rstn), .cmd_start(cmd_start), .cmd_abort(cmd_abort), .cmd_key(cmd_key),
        .cmd_chain(cmd_chain), .cmd_cnt(cmd_cnt), .cmd_din(cmd_din), .blk_din(blk_din),
        .blk_krdy(blk_krdy), .blk_drdy(blk_drdy), .blk_kvld(blk_kvld), .blk_dvld(blk_dvld),
        .blk_dout(blk_dout), .blk_rstn(blk_rstn), .seq_busy(seq_busy), .seq_done(seq_done),
        .seq_err(seq_err), .seq_left(seq_left), .seq_dout(seq_dout), .trig(trig)
    );

    always #5 clk = ~clk;

    // Core model and output monitors, evaluated mid-cycle
    always @(negedge clk) begin
        blk_kvld = 1'b0;
        blk_dvld = 1'b0;
        if (dcnt > 0) begin
            dcnt = dcnt - 1;
            if (dcnt == 0) begin
                blk_dvld = 1'b1;
                blk_dout = din_snap + 128'd1;
            end
        end
        if (kcnt > 0) begin
            kcnt = kcnt - 1;
            if (kcnt == 0) blk_kvld = 1'b1;
        end
        if (blk_drdy && core_en) begin
            dcnt     = core_lat;
            din_snap = blk_din[DOUT_W-1:0];
        end
        if (blk_krdy && core_en) kcnt = 3;
        if (blk_krdy) n_krdy++;
        if (blk_drdy) n_drdy++;
        if (seq_done) n_done++;
        if (trig) trig_len++;
        else if (trig_len != 0) begin
            trig_hist.push_back(trig_len);
            trig_len = 0;
        end
        if (seq_left != left_prev) begin
            left_hist.push_back(seq_left);
            left_prev = seq_left;
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a one-cycle start; returns mid-cycle of the first cycle after the accepting edge
    task automatic pulse_start(input logic key, input logic chain, input logic [15:0] cnt,
                               input logic [DOUT_W-1:0] lo);
        cmd_key   = key;
        cmd_chain = chain;
        cmd_cnt   = cnt;
        cmd_din   = {up_pat, lo};
        cmd_start = 1'b1;
        tick(1);
        cmd_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 3000 && seq_busy; i++) tick(1);
        chk(name, 512'(i < 3000), 512'(1));
    endtask

    typedef struct {
        logic              key;
        logic              chain;
        logic [15:0]       cnt;
        logic [DOUT_W-1:0] lo;
        int                exp_k;
        int                exp_d;
        logic [DOUT_W-1:0] exp_dout;
        logic [DOUT_W-1:0] exp_din_lo;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int k0, d0, dn0, th0, lh0;
        vecs[0] = '{1'b1, 1'b0, 16'd3, 128'd5,   1, 3, 128'd6,   128'd5};
        vecs[1] = '{1'b0, 1'b1, 16'd2, 128'd0,   0, 2, 128'd2,   128'd2};
        vecs[2] = '{1'b0, 1'b0, 16'd0, 128'd9,   0, 0, 128'd2,   128'd9};
        vecs[3] = '{1'b1, 1'b0, 16'd0, 128'd7,   1, 0, 128'd2,   128'd7};
        vecs[4] = '{1'b1, 1'b1, 16'd3, 128'd100, 1, 3, 128'd103, 128'd103};

        tick(2);
        chk("rst_busy", 512'(seq_busy), 512'(0));
        chk("rst_blk_rstn", 512'(blk_rstn), 512'(1));
        chk("rst_strobes", 512'({blk_krdy, blk_drdy, seq_done, seq_err, trig}), 512'(0));
        chk("rst_data", 512'({blk_din, seq_dout, seq_left}), 512'(0));
        rstn = 1'b1;
        tick(2);

        for (int v = 0; v < 5; v++) begin
            k0 = n_krdy; d0 = n_drdy; dn0 = n_done; th0 = trig_hist.size(); lh0 = left_hist.size();
            pulse_start(vecs[v].key, vecs[v].chain, vecs[v].cnt, vecs[v].lo);
            chk("start_busy", 512'(seq_busy), 512'(1));
            chk("start_krdy", 512'(blk_krdy), 512'(vecs[v].key));
            chk("start_drdy", 512'(blk_drdy), 512'(!vecs[v].key && vecs[v].cnt != 16'd0));
            wait_idle("vec_idle_bound");
            tick(2);
            chk("vec_krdy_count", 512'(n_krdy - k0), 512'(vecs[v].exp_k));
            chk("vec_drdy_count", 512'(n_drdy - d0), 512'(vecs[v].exp_d));
            chk("vec_done_count", 512'(n_done - dn0), 512'(1));
            chk("vec_seq_left", 512'(seq_left), 512'(0));
            chk("vec_seq_dout", 512'(seq_dout), 512'(vecs[v].exp_dout));
            chk("vec_din_lo", 512'(blk_din[DOUT_W-1:0]), 512'(vecs[v].exp_din_lo));
            chk("vec_din_hi", 512'(blk_din[DIN_W-1:DOUT_W]), 512'(up_pat));
            chk("vec_trig_runs", 512'(trig_hist.size() - th0), 512'(vecs[v].exp_d));
            for (int j = th0; j < trig_hist.size(); j++) chk("vec_trig_len", 512'(trig_hist[j]), 512'(11));
            chk("vec_left_steps", 512'(left_hist.size() - lh0),
                512'(vecs[v].cnt == 16'd0 ? 0 : int'(vecs[v].cnt) + 1));
            for (int j = lh0; j < left_hist.size(); j++)
                chk("vec_left_value", 512'(left_hist[j]), 512'(int'(vecs[v].cnt) - (j - lh0)));
        end

        // Zero-count start with no key: done in the very first busy cycle, no strobes
        k0 = n_krdy; d0 = n_drdy;
        pulse_start(1'b0, 1'b0, 16'd0, 128'd1);
        chk("cnt0_done", 512'(seq_done), 512'(1));
        chk("cnt0_busy", 512'(seq_busy), 512'(1));
        tick(1);
        chk("cnt0_done_fall", 512'({seq_done, seq_busy}), 512'(0));
        chk("cnt0_no_strobes", 512'((n_krdy - k0) + (n_drdy - d0)), 512'(0));

        // Abort coincident with dvld in DWAIT (seq_dout holds 103 from the last vector)
        dn0 = n_done;
        pulse_start(1'b0, 1'b0, 16'd2, 128'd50);
        chk("abort_drdy", 512'(blk_drdy), 512'(1));
        tick(10);
        chk("abort_trig_before", 512'(trig), 512'(1));
        cmd_abort = 1'b1;
        tick(1);
        cmd_abort = 1'b0;
        chk("abort_blk_rstn", 512'(blk_rstn), 512'(0));
        chk("abort_idle", 512'({seq_busy, seq_done, trig}), 512'(0));
        chk("abort_seq_dout", 512'(seq_dout), 512'(103));
        chk("abort_seq_left", 512'(seq_left), 512'(2));
        tick(1);
        chk("abort_rstn_back", 512'(blk_rstn), 512'(1));
        tick(3);
        chk("abort_no_done", 512'(n_done - dn0), 512'(0));

        // Core never answers
        core_en = 1'b0;
        pulse_start(1'b0, 1'b0, 16'd1, 128'd0);
`ifdef SEQ_TIMEOUT_EN
        tick(1024);
        chk("tmo_err_early", 512'({seq_err, seq_busy}), 512'(1));
        tick(1);
        chk("tmo_err", 512'(seq_err), 512'(1));
        chk("tmo_blk_rstn", 512'(blk_rstn), 512'(0));
        chk("tmo_idle", 512'({seq_busy, trig}), 512'(0));
        tick(2);
        chk("tmo_err_sticky", 512'(seq_err), 512'(1));
        core_en = 1'b1;
        pulse_start(1'b0, 1'b0, 16'd0, 128'd0);
        chk("tmo_err_clear", 512'(seq_err), 512'(0));
        tick(2);
`else
        tick(1100);
        chk("hang_busy", 512'({seq_busy, trig}), 512'(3));
        chk("hang_no_err", 512'(seq_err), 512'(0));
        cmd_abort = 1'b1;
        tick(1);
        cmd_abort = 1'b0;
        chk("hang_abort", 512'({seq_busy, blk_rstn}), 512'(0));
        core_en = 1'b1;
        tick(2);
`endif

        // Start while busy ignored, then asynchronous reset in GAPW
        pulse_start(1'b0, 1'b0, 16'd3, 128'd20);
        begin
            int i;
            for (i = 0; i < 200 && seq_left != 16'd2; i++) tick(1);
            chk("gap_reach_bound", 512'(i < 200), 512'(1));
        end
        pulse_start(1'b1, 1'b1, 16'd7, 128'd99);
        chk("busy_start_left", 512'(seq_left), 512'(2));
        chk("busy_start_din", 512'(blk_din[DOUT_W-1:0]), 512'(20));
        chk("busy_start_krdy", 512'({blk_krdy, seq_busy}), 512'(1));
        rstn = 1'b0;
        #1;
        chk("arst_data", 512'({blk_din, seq_dout, seq_left}), 512'(0));
        chk("arst_flags", 512'({blk_krdy, blk_drdy, seq_busy, seq_done, seq_err, trig}), 512'(0));
        chk("arst_blk_rstn", 512'(blk_rstn), 512'(1));
        tick(2);
        rstn = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
